// File: rtl/led_bar_ramp_pkg.sv
// Shared definitions for the LED bar ramp driver.
//   state_t         : ramp FSM state (IDLE, RAMP_UP, RAMP_DN)
//   MODE_BAR/DOT    : i_mode encodings
//   DEF_TICK_DIV    : default clock cycles per ramp step
//   DEF_BLINK_TICKS : default ramp ticks per overrange blink half-period
package led_bar_ramp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAMP_UP = 2'd1,
    RAMP_DN = 2'd2
  } state_t;

  localparam logic MODE_BAR = 1'b0;
  localparam logic MODE_DOT = 1'b1;

  localparam int DEF_TICK_DIV    = 100000;
  localparam int DEF_BLINK_TICKS = 250;

endpackage

// File: rtl/led_bar_pattern.sv
// Combinational level -> LED pattern mapping.
//   level   : displayed level, 0..N_LEDS
//   mode    : MODE_BAR (LEDs 0..level-1 on) or MODE_DOT (only LED level-1 on)
//   pattern : N_LEDS-bit LED pattern
module led_bar_pattern
  import led_bar_ramp_pkg::*;
#(
  parameter int N_LEDS = 4,
  parameter int LVL_W  = $clog2(N_LEDS + 1)
) (
  input  logic [LVL_W-1:0]  level,
  input  logic              mode,
  output logic [N_LEDS-1:0] pattern
);

  logic [N_LEDS-1:0] bar;
  logic [N_LEDS-1:0] dot;

  always_comb begin
    // Complemented shift of all-ones equals ((1<<level)-1) truncated to
    // N_LEDS bits, including level == N_LEDS (shift-out gives all ones).
    bar = ~({N_LEDS{1'b1}} << level);
    dot = '0;
    if (level != '0) dot = N_LEDS'(1) << (level - LVL_W'(1));
    pattern = (mode == MODE_DOT) ? dot : bar;
  end

endmodule

// File: rtl/led_bar_ramp.sv
// LED bar-graph driver that ramps the displayed level toward a target one
// step per prescaled tick, with bar/dot display modes and overrange flag.
//   i_clk, i_reset_n : clock, synchronous active-low reset
//   i_level          : target level (clamped to N_LEDS)
//   i_mode           : 0 = bar, 1 = dot
//   o_led            : registered LED drive
//   o_level          : currently displayed level
//   o_busy           : displayed level still moving toward target
//   o_ovr            : registered target exceeds N_LEDS
// Optional feature macro: LED_BAR_BLINK_EN (blink the bar while overrange).
module led_bar_ramp
  import led_bar_ramp_pkg::*;
#(
  parameter int N_LEDS      = 4,
  parameter int LVL_W       = $clog2(N_LEDS + 1),  // derived; do not override
  parameter int TICK_DIV    = DEF_TICK_DIV,
  parameter int BLINK_TICKS = DEF_BLINK_TICKS
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [LVL_W-1:0]  i_level,
  input  logic              i_mode,
  output logic [N_LEDS-1:0] o_led,
  output logic [LVL_W-1:0]  o_level,
  output logic              o_busy,
  output logic              o_ovr
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(N_LEDS);

  if (N_LEDS < 2 || N_LEDS > 16 || TICK_DIV < 2 || BLINK_TICKS < 1) begin : g_param_err
    $error("led_bar_ramp: illegal parameter value");
  end

  logic [LVL_W-1:0]  r_target;
  logic [LVL_W-1:0]  r_cur;
  logic              r_ovr;
  logic [CNT_W-1:0]  cnt;
  state_t            state;
  logic              tick;
  logic [N_LEDS-1:0] pattern;
  logic [LVL_W-1:0]  level_clamp;
  logic              blank;

  assign tick        = (cnt == CNT_W'(TICK_DIV - 1));
  assign level_clamp = (i_level > MAX_LVL) ? MAX_LVL : i_level;

`ifdef LED_BAR_BLINK_EN
  localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  logic [BLK_W-1:0] blink_cnt;
  logic             blink_phase;
  assign blank = r_ovr & blink_phase;
`else
  assign blank = 1'b0;
`endif

  led_bar_pattern #(.N_LEDS(N_LEDS), .LVL_W(LVL_W)) u_pattern (
    .level   (r_cur),
    .mode    (i_mode),
    .pattern (pattern)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_target <= '0;
      r_cur    <= '0;
      r_ovr    <= 1'b0;
      cnt      <= '0;
      state    <= IDLE;
      o_led    <= '0;
`ifdef LED_BAR_BLINK_EN
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
`endif
    end else begin
      r_target <= level_clamp;
      r_ovr    <= (i_level > MAX_LVL);
      cnt      <= tick ? '0 : cnt + CNT_W'(1);

      if (r_cur < r_target)      state <= RAMP_UP;
      else if (r_cur > r_target) state <= RAMP_DN;
      else                       state <= IDLE;

      // Direction comes from last cycle's compare; the live compare guards
      // against stepping past a target that moved on this same edge.
      if (tick) begin
        case (state)
          RAMP_UP: if (r_cur < r_target && r_cur < MAX_LVL) r_cur <= r_cur + LVL_W'(1);
          RAMP_DN: if (r_cur > r_target && r_cur != '0)     r_cur <= r_cur - LVL_W'(1);
          default: ;
        endcase
      end

`ifdef LED_BAR_BLINK_EN
      if (!r_ovr) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
      end else if (tick) begin
        if (blink_cnt == BLK_W'(BLINK_TICKS - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BLK_W'(1);
        end
      end
`endif

      o_led <= blank ? '0 : pattern;
    end
  end

  assign o_level = r_cur;
  assign o_busy  = (state != IDLE);
  assign o_ovr   = r_ovr;

endmodule

// File: tb/tb_led_bar_ramp.sv
// Self-checking bench for led_bar_ramp (N_LEDS=4, TICK_DIV=4, BLINK_TICKS=2).
// Stimulus pushes the expected sequence of o_led patterns into a queue; a
// monitor pops one entry each time o_led changes and compares. Directed
// checks cover reset values, step timing, busy, overrange and mode.
module tb_led_bar_ramp;

  localparam int N  = 4;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [LW-1:0] level;
  logic          mode;
  logic [N-1:0]  led;
  logic [LW-1:0] lvl_out;
  logic          busy;
  logic          ovr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] prev_led = '0;
  bit           mon_en   = 1'b1;

  always #5 clk = ~clk;

  led_bar_ramp #(.N_LEDS(N), .TICK_DIV(4), .BLINK_TICKS(2)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_level   (level),
    .i_mode    (mode),
    .o_led     (led),
    .o_level   (lvl_out),
    .o_busy    (busy),
    .o_ovr     (ovr)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every change of o_led must match the next expected pattern.
  always @(negedge clk) begin
    if (!mon_en) begin
      prev_led = led;
    end else if (led !== prev_led) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL led_seq: unexpected change to %b at %0t", led, $time);
      end else begin
        chk("led_seq", int'(led), int'(exp_q.pop_front()));
      end
      prev_led = led;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Let a new target propagate into the FSM, then wait (bounded) for idle.
  task automatic wait_idle();
    int k;
    cyc(3);
    k = 0;
    while (busy && k < 200) begin
      cyc(1);
      k++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    level = '0;
    mode  = 1'b0;
    cyc(3);
    chk("rst_led",  int'(led), 0);
    chk("rst_lvl",  int'(lvl_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovr",  int'(ovr), 0);

    // Ramp 0 -> 3, first tick on the 4th edge after release.
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0011);
    exp_q.push_back(4'b0111);
    level = 3'd3;
    rst_n = 1'b1;
    cyc(3);
    chk("pre_tick_lvl", int'(lvl_out), 0);
    cyc(1);
    chk("tick1_lvl",  int'(lvl_out), 1);
    chk("tick1_busy", int'(busy), 1);
    chk("tick1_led",  int'(led), 0);
    cyc(1);
    chk("led_lag",    int'(led), 1);
    cyc(7);
    chk("lvl3",       int'(lvl_out), 3);
    chk("lvl3_busy",  int'(busy), 1);
    cyc(1);
    chk("busy_fall",  int'(busy), 0);
    chk("led_0111",   int'(led), 7);

    // Ramp down 3 -> 1, no overshoot.
    exp_q.push_back(4'b0011);
    exp_q.push_back(4'b0001);
    level = 3'd1;
    wait_idle();
    cyc(10);
    chk("down_lvl", int'(lvl_out), 1);

    // Target 4, retarget to 1 once level reaches 2.
    exp_q.push_back(4'b0011);
    exp_q.push_back(4'b0001);
    level = 3'd4;
    k = 0;
    while (lvl_out != 3'd2 && k < 100) begin
      cyc(1);
      k++;
    end
    chk("mid_lvl2", int'(lvl_out), 2);
    level = 3'd1;
    wait_idle();
    chk("retarget_lvl", int'(lvl_out), 1);

    // Dot mode at level 3.
    exp_q.push_back(4'b0011);
    exp_q.push_back(4'b0111);
    level = 3'd3;
    wait_idle();
    cyc(2);
    exp_q.push_back(4'b0100);
    mode = 1'b1;
    cyc(1);
    chk("dot_led", int'(led), 4);
    chk("dot_lvl", int'(lvl_out), 3);
    exp_q.push_back(4'b0111);
    mode = 1'b0;
    cyc(1);
    chk("bar_back", int'(led), 7);

    // Overrange: clamp to 4, flag raised one cycle later.
`ifdef LED_BAR_BLINK_EN
    mon_en = 1'b0;
`else
    exp_q.push_back(4'b1111);
`endif
    level = 3'd7;
    cyc(1);
    chk("ovr_set", int'(ovr), 1);
    wait_idle();
    chk("ovr_lvl", int'(lvl_out), 4);
`ifdef LED_BAR_BLINK_EN
    k = 0;
    while (led != 4'b0000 && k < 40) begin
      cyc(1);
      k++;
    end
    chk("blink_off", int'(led), 0);
`else
    cyc(20);
    chk("ovr_steady", int'(led), 15);
`endif
    level = 3'd4;
    cyc(1);
    chk("ovr_clr", int'(ovr), 0);
    cyc(4);
    chk("ovr_exit_led", int'(led), 15);
    mon_en = 1'b1;

    // Reset mid-ramp down from 4.
    exp_q.push_back(4'b0111);
    level = 3'd0;
    k = 0;
    while (led != 4'b0111 && k < 100) begin
      cyc(1);
      k++;
    end
    chk("ramp_dn_led", int'(led), 7);
    exp_q.push_back(4'b0000);
    rst_n = 1'b0;
    cyc(1);
    chk("mid_rst_led",  int'(led), 0);
    chk("mid_rst_lvl",  int'(lvl_out), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ovr",  int'(ovr), 0);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0011);
    rst_n = 1'b1;
    level = 3'd2;
    wait_idle();
    chk("restart_lvl", int'(lvl_out), 2);
    cyc(3);
    chk("restart_led", int'(led), 3);
    chk("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule
